tremolo_mod: RTL and testbench

//  Stereo tremolo (amplitude modulation) with an internal phase-accumulator LFO.

---
 rtl/tremolo_mod.sv | 124 ++++++++++++
 tb/tb_tremolo_mod.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tremolo_mod.sv
// rtl/tremolo_mod.sv - stereo tremolo with phase-accumulator LFO, 3-stage pipeline
module tremolo_mod #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int DEPTH_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] audio_left_in,
  input  logic signed [DATA_WIDTH-1:0] audio_right_in,
  input  logic [PHASE_WIDTH-1:0]       fcw,
  input  logic [DEPTH_WIDTH-1:0]       depth,
  input  logic [1:0]                   mode,
  input  logic                         phase_sync,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] audio_left_out,
  output logic signed [DATA_WIDTH-1:0] audio_right_out,
  output logic [15:0]                  lfo_out
);

  localparam int PROD_W = DATA_WIDTH + 18;

  logic [PHASE_WIDTH-1:0] r_phase;
  logic [PHASE_WIDTH-1:0] w_phase_used;
  logic [15:0]            w_u;
  logic [7:0]             w_depth_ext;
  logic [23:0]            w_depth_prod;
  logic [16:0]            w_gain;

  logic                         r_s1_valid;
  logic signed [DATA_WIDTH-1:0] r_s1_l;
  logic signed [DATA_WIDTH-1:0] r_s1_r;
  logic [15:0]                  r_s1_u;
  logic [16:0]                  r_s1_g;

  logic                         r_s2_valid;
  logic signed [PROD_W-1:0]     r_s2_pl;
  logic signed [PROD_W-1:0]     r_s2_pr;
  logic [15:0]                  r_s2_u;

  logic signed [PROD_W-1:0]     w_xl_ext;
  logic signed [PROD_W-1:0]     w_xr_ext;
  logic signed [PROD_W-1:0]     w_g_ext;
  logic signed [PROD_W-1:0]     w_prod_l;
  logic signed [PROD_W-1:0]     w_prod_r;

  // A sync arriving with a sample makes that sample see phase zero.
  assign w_phase_used = phase_sync ? '0 : r_phase;

  always_comb begin
    w_u = 16'd0;
    case (mode)
      2'd0:    w_u = w_phase_used[PHASE_WIDTH-1] ? ~w_phase_used[PHASE_WIDTH-2 -: 16]
                                                 :  w_phase_used[PHASE_WIDTH-2 -: 16];
      2'd1:    w_u = {16{w_phase_used[PHASE_WIDTH-1]}};
      2'd2:    w_u = ~w_phase_used[PHASE_WIDTH-1 -: 16];
      default: w_u = 16'd0;
    endcase
  end

  generate
    if (DEPTH_WIDTH >= 8) begin : g_depth_trunc
      assign w_depth_ext = depth[DEPTH_WIDTH-1 -: 8];
    end else begin : g_depth_pad
      assign w_depth_ext = {depth, {(8-DEPTH_WIDTH){1'b0}}};
    end
  endgenerate

  assign w_depth_prod = {16'd0, w_depth_ext} * {8'd0, w_u};
  assign w_gain       = 17'h10000 - {1'b0, w_depth_prod[23:8]};

  assign w_xl_ext = {{18{r_s1_l[DATA_WIDTH-1]}}, r_s1_l};
  assign w_xr_ext = {{18{r_s1_r[DATA_WIDTH-1]}}, r_s1_r};
  assign w_g_ext  = {{(DATA_WIDTH+1){1'b0}}, r_s1_g};
  assign w_prod_l = w_xl_ext * w_g_ext;
  assign w_prod_r = w_xr_ext * w_g_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase         <= '0;
      r_s1_valid      <= 1'b0;
      r_s1_l          <= '0;
      r_s1_r          <= '0;
      r_s1_u          <= '0;
      r_s1_g          <= '0;
      r_s2_valid      <= 1'b0;
      r_s2_pl         <= '0;
      r_s2_pr         <= '0;
      r_s2_u          <= '0;
      out_valid       <= 1'b0;
      audio_left_out  <= '0;
      audio_right_out <= '0;
      lfo_out         <= '0;
    end else begin
      if (in_valid)        r_phase <= w_phase_used + fcw;
      else if (phase_sync) r_phase <= '0;

      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_l <= audio_left_in;
        r_s1_r <= audio_right_in;
        r_s1_u <= w_u;
        r_s1_g <= w_gain;
      end

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_pl <= w_prod_l;
        r_s2_pr <= w_prod_r;
        r_s2_u  <= r_s1_u;
      end

      // Taking bits [DW+15:16] of the signed product is the floor >>> 16.
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        audio_left_out  <= r_s2_pl[DATA_WIDTH+15:16];
        audio_right_out <= r_s2_pr[DATA_WIDTH+15:16];
        lfo_out         <= r_s2_u;
      end
    end
  end

endmodule

// File: tb/tb_tremolo_mod.sv
// tb/tb_tremolo_mod.sv - scoreboard bench for tremolo_mod
module tb_tremolo_mod;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] audio_left_in;
  logic signed [15:0] audio_right_in;
  logic [23:0]        fcw;
  logic [7:0]         depth;
  logic [1:0]         mode;
  logic               phase_sync;
  logic               out_valid;
  logic signed [15:0] audio_left_out;
  logic signed [15:0] audio_right_out;
  logic [15:0]        lfo_out;

  always #5 clk = ~clk;

  tremolo_mod #(.DATA_WIDTH(16), .PHASE_WIDTH(24), .DEPTH_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .audio_left_in(audio_left_in), .audio_right_in(audio_right_in),
    .fcw(fcw), .depth(depth), .mode(mode), .phase_sync(phase_sync),
    .out_valid(out_valid), .audio_left_out(audio_left_out),
    .audio_right_out(audio_right_out), .lfo_out(lfo_out)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] u;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int x, input int d, input int u);
    longint g;
    longint p;
    g = 65536 - ((longint'(d) * longint'(u)) >> 8);
    p = longint'(x) * g;
    p = p >>> 16;
    return p[15:0];
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 16'd1, 16'd0);
        end else begin
          e = sb.pop_front();
          chk("left", audio_left_out, e.l);
          chk("right", audio_right_out, e.r);
          chk("lfo", lfo_out, e.u);
          chk("latency", 16'(cyc - e.issue), 16'd3);
        end
      end
    end
  end

  task automatic send(input int l, input int r, input logic [23:0] f, input logic [7:0] d,
                      input logic [1:0] m, input logic s, input bit push,
                      input logic [15:0] el, input logic [15:0] er, input logic [15:0] eu);
    in_valid       = 1'b1;
    audio_left_in  = l[15:0];
    audio_right_in = r[15:0];
    fcw            = f;
    depth          = d;
    mode           = m;
    phase_sync     = s;
    if (push) sb.push_back('{el, er, eu, cyc});
    @(negedge clk);
    in_valid   = 1'b0;
    phase_sync = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    chk({name, "_drained"}, 16'(sb.size()), 16'd0);
    sb.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  logic [15:0] tri_seq [10];

  initial begin : stim
    rst_n = 1'b0; in_valid = 1'b0; audio_left_in = '0; audio_right_in = '0;
    fcw = '0; depth = '0; mode = '0; phase_sync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_left", audio_left_out, 16'd0);
    chk("rst_right", audio_right_out, 16'd0);
    chk("rst_lfo", lfo_out, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // depth 0 is an exact passthrough
    send(1000, -1000, 24'h0, 8'd0, 2'd0, 1'b0, 1'b1, 16'd1000, 16'hFC18, 16'h0000);
    drain("t1");

    // square: U=0 then U=FFFF (g=257)
    send(16384, -16384, 24'h800000, 8'd255, 2'd1, 1'b1, 1'b1, 16'd16384, 16'hC000, 16'h0000);
    send(16384, -16384, 24'h800000, 8'd255, 2'd1, 1'b0, 1'b1, 16'd64, 16'hFFBF, 16'hFFFF);
    drain("t2");

    // triangle sweep with idle gaps
    tri_seq = '{16'h0000, 16'h2000, 16'h4000, 16'h6000, 16'h8000,
                16'hA000, 16'hC000, 16'hE000, 16'hFFFF, 16'hDFFF};
    for (int k = 0; k < 10; k++) begin
      send(32767, 0, 24'h100000, 8'd255, 2'd0, (k == 0), 1'b1,
           model(32767, 255, int'(tri_seq[k])), 16'd0, tri_seq[k]);
      @(negedge clk);
    end
    drain("t3");

    // back-to-back strobes, half depth square
    for (int i = 0; i < 8; i++) begin
      int l;
      int r;
      int u;
      l = i * 1000 - 3500;
      r = 1 - i * 777;
      u = (i % 2 == 1) ? 65535 : 0;
      send(l, r, 24'h800000, 8'd128, 2'd1, (i == 0), 1'b1,
           model(l, 128, u), model(r, 128, u), u[15:0]);
    end
    drain("t4");

    // reset with a sample in flight
    send(5, -5, 24'h400000, 8'd0, 2'd2, 1'b1, 1'b1, 16'd5, 16'hFFFB, 16'hFFFF);
    drain("t5a");
    send(7, -7, 24'h400000, 8'd0, 2'd2, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("t5_rst_left", audio_left_out, 16'd0);
    chk("t5_rst_right", audio_right_out, 16'd0);
    chk("t5_rst_lfo", lfo_out, 16'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(9, -9, 24'h400000, 8'd0, 2'd2, 1'b0, 1'b1, 16'd9, 16'hFFF7, 16'hFFFF);
    drain("t5b");

    // ramp with phase_sync
    send(10000, -10000, 24'h400000, 8'd255, 2'd2, 1'b1, 1'b1, 16'd39, 16'hFFD8, 16'hFFFF);
    send(10000, -10000, 24'h400000, 8'd255, 2'd2, 1'b0, 1'b1, 16'h09E1, 16'hF61E, 16'hBFFF);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
